// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks the EX and MEM/WB slot destinations for the forwarding
// controller and detects load-use hazards, stalling decode and injecting bubbles.
module hazard_tracker #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [23:0]      id_instruction,
  input  logic             id_valid,
  input  logic             mem_stall,
  input  logic             flush,
  output logic [3:0]       reg_hazard,
  output logic             write_instruction,
  output logic [3:0]       reg_hazard_2,
  output logic             write_instruction_2,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned REG_W = 4;
  localparam int unsigned LAT_W = 2;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LATENCY - 1);

  localparam logic [1:0]       CLS_ALU_REG = 2'b00;
  localparam logic [1:0]       CLS_ALU_IMM = 2'b01;
  localparam logic [1:0]       CLS_MEM     = 2'b10;
  localparam logic [3:0]       OP_LOAD     = 4'b0000;
  localparam logic [3:0]       OP_STORE    = 4'b0001;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } slot_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  slot_t            slot1, slot2, dec;
  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic             reads_b, detect;
  logic [1:0]       cls;
  logic [3:0]       op, ra, rb;
  logic             unused_bits;

  assign cls         = id_instruction[23:22];
  assign op          = id_instruction[21:18];
  assign ra          = id_instruction[13:10];
  assign rb          = id_instruction[9:6];
  assign unused_bits = ^id_instruction[5:0];

  // Decode the instruction in ID into a slot record and its rB usage
  always_comb begin
    dec         = '0;
    reads_b     = 1'b0;
    dec.rd      = id_instruction[17:14];
    dec.is_load = (cls == CLS_MEM) && (op == OP_LOAD);
    dec.we      = (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM) || dec.is_load;
    reads_b     = (cls == CLS_ALU_REG) || ((cls == CLS_MEM) && (op == OP_STORE));
  end

  // Load in EX whose rd is a source of the decode instruction (rA read by every class)
  always_comb begin
    detect = slot1.is_load && id_valid && !flush &&
             ((ra == slot1.rd) || (reads_b && (rb == slot1.rd)));
  end

  // FSM state register and remaining-stall counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: frozen pipeline holds everything, flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_stall) begin
      if (flush) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (detect && (LOAD_LATENCY > 1)) begin
              state_nxt = STALL;
              cnt_nxt   = LAT_INIT;
            end
          end
          STALL: begin
            cnt_nxt = cnt - LAT_W'(1);
            if (cnt == LAT_W'(1)) begin
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Stall output: detect in IDLE, held high in STALL, killed by flush
  always_comb begin
    load_use_stall = 1'b0;
    if (!flush) begin
      case (state)
        IDLE:    load_use_stall = detect;
        STALL:   load_use_stall = 1'b1;
        default: load_use_stall = 1'b0;
      endcase
    end
  end

  // Slot pipeline: bubble into EX on flush, stall or invalid decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot1 <= '0;
      slot2 <= '0;
    end else if (!mem_stall) begin
      slot2 <= slot1;
      slot1 <= (flush || load_use_stall || !id_valid) ? slot_t'('0) : dec;
    end
  end

  // Saturating count of unfrozen stall cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (load_use_stall && !mem_stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign reg_hazard          = slot1.rd;
  assign write_instruction   = slot1.we;
  assign reg_hazard_2        = slot2.rd;
  assign write_instruction_2 = slot2.we;

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: three configurations share one stimulus stream and
// are compared each cycle against a remaining-stall-cycles reference model.
module tb_hazard_tracker;

  localparam logic [23:0] LOAD_R3 = 24'h80C400;
  localparam logic [23:0] ADD_R5  = 24'h014C80;
  localparam logic [23:0] IMM_RB3 = {2'b01, 4'h0, 4'd7, 4'd1, 4'd3, 6'd0};
  localparam logic [23:0] ST_RB3  = {2'b10, 4'h1, 4'd0, 4'd1, 4'd3, 6'd0};

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] instr;
  logic        valid, ms, fl;

  logic [3:0]  rh[3];
  logic [3:0]  rh2[3];
  logic        wi[3];
  logic        wi2[3];
  logic        lus[3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;
  logic [15:0] sc_a[3];

  assign sc_a[0] = sc0;
  assign sc_a[1] = sc1;
  assign sc_a[2] = {12'd0, sc2};

  always #5 clock = ~clock;

  hazard_tracker #(.LOAD_LATENCY(1), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .id_instruction(instr), .id_valid(valid),
    .mem_stall(ms), .flush(fl), .reg_hazard(rh[0]), .write_instruction(wi[0]),
    .reg_hazard_2(rh2[0]), .write_instruction_2(wi2[0]),
    .load_use_stall(lus[0]), .stall_count(sc0));

  hazard_tracker #(.LOAD_LATENCY(3), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .id_instruction(instr), .id_valid(valid),
    .mem_stall(ms), .flush(fl), .reg_hazard(rh[1]), .write_instruction(wi[1]),
    .reg_hazard_2(rh2[1]), .write_instruction_2(wi2[1]),
    .load_use_stall(lus[1]), .stall_count(sc1));

  hazard_tracker #(.LOAD_LATENCY(2), .CNT_W(4)) u2 (
    .clock(clock), .reset(reset), .id_instruction(instr), .id_valid(valid),
    .mem_stall(ms), .flush(fl), .reg_hazard(rh[2]), .write_instruction(wi[2]),
    .reg_hazard_2(rh2[2]), .write_instruction_2(wi2[2]),
    .load_use_stall(lus[2]), .stall_count(sc2));

  int total = 0;
  int bad   = 0;
  int hi[3];

  // reference model state: slot contents, stall cycles still owed, stall counter
  int       lat_of[3] = '{1, 3, 2};
  int       max_of[3] = '{65535, 65535, 15};
  int       m_rd1[3], m_rd2[3], m_left[3], m_cnt[3];
  bit       m_we1[3], m_we2[3], m_ld1[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_load(input logic [23:0] x);
    return x[23:22] == 2'b10 && x[21:18] == 4'd0;
  endfunction

  function automatic bit writes_rd(input logic [23:0] x);
    return x[23:22] == 2'b00 || x[23:22] == 2'b01 || is_load(x);
  endfunction

  function automatic bit uses_rb(input logic [23:0] x);
    return x[23:22] == 2'b00 || (x[23:22] == 2'b10 && x[21:18] == 4'd1);
  endfunction

  function automatic bit m_detect(input int i);
    if (!m_ld1[i] || !valid || fl) return 0;
    if (int'(instr[13:10]) == m_rd1[i]) return 1;
    return uses_rb(instr) && int'(instr[9:6]) == m_rd1[i];
  endfunction

  function automatic bit m_lus(input int i);
    return !fl && (m_left[i] > 0 || m_detect(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rd1[i] = 0; m_rd2[i] = 0; m_we1[i] = 0; m_we2[i] = 0;
      m_ld1[i] = 0; m_left[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit e, d, squash;
    if (ms) return;
    for (int i = 0; i < 3; i++) begin
      e = m_lus(i);
      d = m_detect(i);
      squash = fl || e || !valid;
      m_rd2[i] = m_rd1[i];
      m_we2[i] = m_we1[i];
      m_rd1[i] = squash ? 0 : int'(instr[17:14]);
      m_we1[i] = squash ? 0 : writes_rd(instr);
      m_ld1[i] = squash ? 0 : is_load(instr);
      if (fl)                m_left[i] = 0;
      else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
      else if (d)            m_left[i] = lat_of[i] - 1;
      if (e && m_cnt[i] < max_of[i]) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      hi[i] += int'(lus[i]);
      check($sformatf("rh%0d", i),  32'(rh[i]),   32'(m_rd1[i]));
      check($sformatf("wi%0d", i),  32'(wi[i]),   32'(m_we1[i]));
      check($sformatf("rh2_%0d", i), 32'(rh2[i]), 32'(m_rd2[i]));
      check($sformatf("wi2_%0d", i), 32'(wi2[i]), 32'(m_we2[i]));
      check($sformatf("lus%0d", i), 32'(lus[i]),  32'(m_lus(i)));
      check($sformatf("sc%0d", i),  32'(sc_a[i]), 32'(m_cnt[i]));
    end
  endtask

  // one cycle: drive at negedge, check mid-cycle, advance model on the edge
  task automatic cyc(input logic [23:0] in, input logic v, input logic m, input logic f);
    instr = in; valid = v; ms = m; fl = f;
    #1 check_all();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; instr = '0; valid = 1'b0; ms = 1'b0; fl = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) hi[i] = 0;
  endtask

  initial begin
    reset = 1'b1; instr = '0; valid = 1'b0; ms = 1'b0; fl = 1'b0;
    model_reset();
    do_reset();

    // async reset in the middle of a stall window
    cyc(ADD_R5, 1, 0, 0);
    cyc(LOAD_R3, 1, 0, 0);
    cyc(ADD_R5, 1, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("arst_rh",  32'(rh[1]),   32'd0);
    check("arst_wi",  32'(wi[1]),   32'd0);
    check("arst_rh2", 32'(rh2[1]),  32'd0);
    check("arst_lus", 32'(lus[1]),  32'd0);
    check("arst_sc",  32'(sc_a[1]), 32'd0);
    check_all();
    @(negedge clock);
    reset = 1'b0;
    cyc(ADD_R5, 1, 0, 0);
    check("first_rh", 32'(rh[0]), 32'd5);
    check("first_wi", 32'(wi[0]), 32'd1);
    cyc('0, 0, 0, 0);
    check("first_rh2", 32'(rh2[0]), 32'd5);

    // load-use with held consumer
    do_reset();
    cyc(LOAD_R3, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(ADD_R5, 1, 0, 0);
    check("lu_hi_l1", 32'(hi[0]), 32'd1);
    check("lu_hi_l3", 32'(hi[1]), 32'd3);
    check("lu_hi_l2", 32'(hi[2]), 32'd2);
    check("lu_sc_l3", 32'(sc_a[1]), 32'd3);

    // mem_stall inside the window stretches it without counting
    do_reset();
    cyc(LOAD_R3, 1, 0, 0);
    cyc(ADD_R5, 1, 0, 0);
    cyc(ADD_R5, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(ADD_R5, 1, 0, 0);
    check("ms_hi_l1", 32'(hi[0]), 32'd1);
    check("ms_hi_l3", 32'(hi[1]), 32'd4);
    check("ms_hi_l2", 32'(hi[2]), 32'd3);
    check("ms_sc_l3", 32'(sc_a[1]), 32'd3);
    check("ms_sc_l1", 32'(sc_a[0]), 32'd1);

    // rB ignored for ALU-imm, used for store
    do_reset();
    cyc(LOAD_R3, 1, 0, 0);
    cyc(IMM_RB3, 1, 0, 0);
    check("imm_hi", 32'(hi[1]), 32'd0);
    do_reset();
    cyc(LOAD_R3, 1, 0, 0);
    cyc(ST_RB3, 1, 0, 0);
    check("st_hi", 32'(hi[0]), 32'd1);

    // flush during STALL
    do_reset();
    cyc(LOAD_R3, 1, 0, 0);
    cyc(ADD_R5, 1, 0, 0);
    cyc(ADD_R5, 1, 0, 1);
    check("fl_wi", 32'(wi[1]), 32'd0);
    cyc(ADD_R5, 1, 0, 0);
    check("fl_hi", 32'(hi[1]), 32'd1);

    // counter saturation in the 4-bit instance
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(LOAD_R3, 1, 0, 0);
      for (int j = 0; j < 3; j++) cyc(ADD_R5, 1, 0, 0);
    end
    check("sat_sc_w4", 32'(sc_a[2]), 32'd15);
    check("sat_sc_l3", 32'(sc_a[1]), 32'd36);
    check("sat_sc_l1", 32'(sc_a[0]), 32'd12);

    // randomized traffic biased toward register collisions and loads/stores
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [23:0] x;
      logic        v, m, f;
      x = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      v = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 6) == 0);
      f = !m && ($urandom_range(0, 11) == 0);
      cyc(x, v, m, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
